// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad entry block.
// - Scanner code constants (one per key of the 3x4 matrix).
// - KEY_STAR / KEY_HASH decoded key values.
// - Debounce FSM state type.
// - decode_key(): scanner code -> {valid, key[3:0]}. Invalid codes return valid=0.
package keypad_pkg;

  localparam logic [7:0] CODE_1    = 8'h01;
  localparam logic [7:0] CODE_2    = 8'h02;
  localparam logic [7:0] CODE_3    = 8'h04;
  localparam logic [7:0] CODE_4    = 8'h08;
  localparam logic [7:0] CODE_5    = 8'h10;
  localparam logic [7:0] CODE_6    = 8'h20;
  localparam logic [7:0] CODE_7    = 8'h40;
  localparam logic [7:0] CODE_8    = 8'h80;
  localparam logic [7:0] CODE_9    = 8'h90;
  localparam logic [7:0] CODE_0    = 8'hA0;
  localparam logic [7:0] CODE_STAR = 8'hB0;
  localparam logic [7:0] CODE_HASH = 8'hC0;

  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } kp_state_e;

  typedef struct packed {
    logic       valid;
    logic [3:0] key;
  } key_dec_t;

  // Map a scanner code to its key value; anything off the table is "no key".
  function automatic key_dec_t decode_key(input logic [7:0] code);
    key_dec_t r;
    r.valid = 1'b1;
    r.key   = 4'd0;
    case (code)
      CODE_1:    r.key = 4'd1;
      CODE_2:    r.key = 4'd2;
      CODE_3:    r.key = 4'd3;
      CODE_4:    r.key = 4'd4;
      CODE_5:    r.key = 4'd5;
      CODE_6:    r.key = 4'd6;
      CODE_7:    r.key = 4'd7;
      CODE_8:    r.key = 4'd8;
      CODE_9:    r.key = 4'd9;
      CODE_0:    r.key = 4'd0;
      CODE_STAR: r.key = KEY_STAR;
      CODE_HASH: r.key = KEY_HASH;
      default:   r.valid = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/keypad_entry_if.sv
// Bus between the scanner side and keypad_entry.
// slave  : the keypad_entry block (consumes data_in, drives key/entry results).
// master : the upstream/observer side (drives data_in, observes results).
interface keypad_entry_if;
  logic [7:0]  data_in;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] digits;
  logic [2:0]  digit_count;
  logic        overflow;
  logic        entry_valid;
  logic [15:0] entry_value;

  modport slave (
    input  data_in,
    output key_valid, key_code, digits, digit_count, overflow,
           entry_valid, entry_value
  );

  modport master (
    output data_in,
    input  key_valid, key_code, digits, digit_count, overflow,
           entry_valid, entry_value
  );
endinterface

// File: rtl/keypad_debounce.sv
// Debounces the scanner code into single key-press events.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   data_in[7:0]     : raw scanner code (0 or off-table = no key)
//   key_valid        : registered one-cycle pulse per accepted press
//   key_code[3:0]    : registered decoded key, held until the next event
//   accept_c         : combinational strobe, high in the cycle whose edge accepts a press
//   accept_key_c[3:0]: key being accepted (valid with accept_c)
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       accept_c,
  output logic [3:0] accept_key_c
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  kp_state_e        state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [3:0]       cand_q, cand_nxt;
  key_dec_t         dec;

  // State, counter and candidate registers plus registered event outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cand_q    <= 4'd0;
      key_valid <= 1'b0;
      key_code  <= 4'd0;
    end else begin
      state_q   <= state_nxt;
      cnt_q     <= cnt_nxt;
      cand_q    <= cand_nxt;
      key_valid <= accept_c;
      if (accept_c) key_code <= cand_q;
    end
  end

  // Next-state logic. The counter holds the number of consecutive matching
  // samples already seen, so the press/release completes on the edge that
  // would bring it to DEBOUNCE_CYCLES.
  always_comb begin
    state_nxt    = state_q;
    cnt_nxt      = cnt_q;
    cand_nxt     = cand_q;
    accept_c     = 1'b0;
    accept_key_c = cand_q;
    dec          = decode_key(data_in);

    case (state_q)
      IDLE: begin
        if (dec.valid) begin
          cand_nxt  = dec.key;
          cnt_nxt   = CNT_ONE;
          state_nxt = PRESS_WAIT;
        end
      end

      PRESS_WAIT: begin
        if (dec.valid && dec.key == cand_q) begin
          if (cnt_q == CNT_LAST) begin
            accept_c  = 1'b1;
            cnt_nxt   = '0;
            state_nxt = HELD;
          end else begin
            cnt_nxt = cnt_q + CNT_ONE;
          end
        end else if (dec.valid) begin
          cand_nxt = dec.key;
          cnt_nxt  = CNT_ONE;
        end else begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end

      HELD: begin
        if (!dec.valid) begin
          cnt_nxt   = CNT_ONE;
          state_nxt = RELEASE_WAIT;
        end
      end

      RELEASE_WAIT: begin
        if (dec.valid) begin
          cnt_nxt   = '0;
          state_nxt = HELD;
        end else if (cnt_q == CNT_LAST) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt_q + CNT_ONE;
        end
      end

      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/keypad_entry.sv
// Keypad entry: debounced key events plus a BCD digit buffer with edit/commit.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   kp (slave) : data_in in; key_valid, key_code, digits, digit_count,
//                overflow, entry_valid, entry_value out (all registered)
// Build option: define KEYPAD_ENTRY_BACKSPACE_EN to make '*' delete the newest
// digit instead of clearing the whole buffer.
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned MAX_DIGITS      = 4
) (
  input  logic           clk,
  input  logic           reset,
  keypad_entry_if.slave  kp
);

  localparam int unsigned BUF_W    = MAX_DIGITS * 4;
  localparam logic [15:0] BUF_MASK = 16'((32'd1 << BUF_W) - 32'd1);
  localparam logic [2:0]  CNT_MAX  = 3'(MAX_DIGITS);

  logic       accept_c;
  logic [3:0] accept_key_c;

  keypad_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk          (clk),
    .reset        (reset),
    .data_in      (kp.data_in),
    .key_valid    (kp.key_valid),
    .key_code     (kp.key_code),
    .accept_c     (accept_c),
    .accept_key_c (accept_key_c)
  );

  // Buffer action applied on the same edge that raises key_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      kp.digits      <= 16'h0000;
      kp.digit_count <= 3'd0;
      kp.overflow    <= 1'b0;
      kp.entry_valid <= 1'b0;
      kp.entry_value <= 16'h0000;
    end else begin
      kp.entry_valid <= 1'b0;
      if (accept_c) begin
        if (accept_key_c < 4'd10) begin
          if (kp.digit_count < CNT_MAX) begin
            kp.digits      <= {kp.digits[11:0], accept_key_c} & BUF_MASK;
            kp.digit_count <= kp.digit_count + 3'd1;
          end else begin
            kp.overflow <= 1'b1;
          end
        end else if (accept_key_c == KEY_STAR) begin
`ifdef KEYPAD_ENTRY_BACKSPACE_EN
          kp.digits <= {4'h0, kp.digits[15:4]};
          if (kp.digit_count != 3'd0) kp.digit_count <= kp.digit_count - 3'd1;
          kp.overflow <= 1'b0;
`else
          kp.digits      <= 16'h0000;
          kp.digit_count <= 3'd0;
          kp.overflow    <= 1'b0;
`endif
        end else if (accept_key_c == KEY_HASH && kp.digit_count != 3'd0) begin
          kp.entry_value <= kp.digits;
          kp.entry_valid <= 1'b1;
          kp.digits      <= 16'h0000;
          kp.digit_count <= 3'd0;
          kp.overflow    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_entry.sv
// Testbench for keypad_entry: directed scenarios plus randomized key bouncing,
// all checked cycle by cycle against a behavioural model of the key/buffer rules.
module tb_keypad_entry;

  localparam int D   = 16;
  localparam int MAX = 4;

  logic clk;
  logic reset;
  int   n_total;
  int   n_bad;

  keypad_entry_if kp ();

  keypad_entry #(
    .DEBOUNCE_CYCLES(D),
    .MAX_DIGITS     (MAX)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .kp   (kp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  bit         m_pressed;
  int         m_run;
  int         m_zrun;
  int         m_cand;
  int         m_q[$];
  bit         m_ovf;
  int         m_entry;
  int         m_kcode;
  bit         m_kv;
  bit         m_ev;
  int         kv_pulses;
  int         ev_pulses;

  logic [7:0] code_tab [12];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scanner code table: index = key value
  function automatic void decode(input logic [7:0] d, output bit v, output int k);
    v = 1'b0;
    k = 0;
    for (int i = 0; i < 12; i++) begin
      if (d == code_tab[i]) begin
        v = 1'b1;
        k = i;
      end
    end
  endfunction

  function automatic int pack_q();
    int val = 0;
    foreach (m_q[i]) val = val * 16 + m_q[i];
    return val;
  endfunction

  task automatic model_apply(input int k);
    if (k < 10) begin
      if (m_q.size() < MAX) m_q.push_back(k);
      else m_ovf = 1'b1;
    end else if (k == 10) begin
`ifdef KEYPAD_ENTRY_BACKSPACE_EN
      if (m_q.size() > 0) void'(m_q.pop_back());
`else
      m_q.delete();
`endif
      m_ovf = 1'b0;
    end else begin
      if (m_q.size() > 0) begin
        m_entry = pack_q();
        m_ev    = 1'b1;
        m_q.delete();
        m_ovf   = 1'b0;
      end
    end
  endtask

  // One clock edge of the model: a press is a run of D identical valid keys
  // while released; a release is a run of D no-key samples while pressed.
  task automatic model_step(input logic [7:0] d, input bit rst);
    bit v;
    int k;
    m_kv = 1'b0;
    m_ev = 1'b0;
    if (rst) begin
      m_pressed = 1'b0; m_run = 0; m_zrun = 0; m_cand = 0;
      m_q.delete(); m_ovf = 1'b0; m_entry = 0; m_kcode = 0;
      return;
    end
    decode(d, v, k);
    if (!m_pressed) begin
      if (v) begin
        if (m_run > 0 && k == m_cand) m_run++;
        else begin
          m_cand = k;
          m_run  = 1;
        end
      end else begin
        m_run = 0;
      end
      if (m_run == D) begin
        m_pressed = 1'b1;
        m_run     = 0;
        m_zrun    = 0;
        m_kv      = 1'b1;
        m_kcode   = k;
        model_apply(k);
      end
    end else begin
      if (!v) m_zrun++;
      else m_zrun = 0;
      if (m_zrun == D) begin
        m_pressed = 1'b0;
        m_zrun    = 0;
      end
    end
  endtask

  // Drive one cycle, advance the model, compare all outputs just after the edge.
  task automatic cycle(input logic [7:0] d, input bit rst = 1'b0);
    kp.data_in = d;
    reset      = rst;
    @(posedge clk);
    model_step(d, rst);
    #1;
    if (kp.key_valid === 1'b1) kv_pulses++;
    if (kp.entry_valid === 1'b1) ev_pulses++;
    check("key_valid",   32'(kp.key_valid),   32'(m_kv));
    check("key_code",    32'(kp.key_code),    32'(m_kcode));
    check("digits",      32'(kp.digits),      32'(pack_q()));
    check("digit_count", 32'(kp.digit_count), 32'(m_q.size()));
    check("overflow",    32'(kp.overflow),    32'(m_ovf));
    check("entry_valid", 32'(kp.entry_valid), 32'(m_ev));
    check("entry_value", 32'(kp.entry_value), 32'(m_entry));
  endtask

  task automatic press(input logic [7:0] code);
    for (int i = 0; i < D + 4; i++) cycle(code);
    for (int i = 0; i < D + 4; i++) cycle(8'h00);
  endtask

  initial begin
    int first;
    n_total = 0;
    n_bad   = 0;
    kv_pulses = 0;
    ev_pulses = 0;
    code_tab = '{8'hA0, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                 8'h80, 8'h90, 8'hB0, 8'hC0};
    kp.data_in = 8'h00;
    reset = 1'b1;

    // Reset state
    for (int i = 0; i < 3; i++) cycle(8'h00, 1'b1);
    check("rst_digits", 32'(kp.digits), 32'h0);
    check("rst_key_code", 32'(kp.key_code), 32'h0);

    // Single key '5': exactly one event, no repeat while held
    kv_pulses = 0;
    for (int i = 0; i < D; i++) cycle(8'h10);
    check("k5_valid_at_D", 32'(kp.key_valid), 32'h1);
    check("k5_code", 32'(kp.key_code), 32'h5);
    check("k5_digits", 32'(kp.digits), 32'h0005);
    check("k5_count", 32'(kp.digit_count), 32'h1);
    for (int i = 0; i < 100; i++) cycle(8'h10);
    check("k5_one_pulse", 32'(kv_pulses), 32'h1);
    for (int i = 0; i < D + 2; i++) cycle(8'h00);
    cycle(8'hB0, 1'b1);  // clean slate via reset
    cycle(8'h00, 1'b1);

    // Bounce: event D cycles after the last rise
    for (int i = 0; i < 10; i++) cycle(8'h10);
    for (int i = 0; i < 3; i++) cycle(8'h00);
    first = 0;
    for (int i = 1; i <= D + 4; i++) begin
      cycle(8'h10);
      if (kp.key_valid === 1'b1 && first == 0) first = i;
    end
    check("bounce_latency", 32'(first), 32'(D));
    for (int i = 0; i < D + 2; i++) cycle(8'h00);
    press(8'hB0);  // clear buffer

    // 1,2,3,4,5 -> overflow; then commit
    press(8'h01); press(8'h02); press(8'h04); press(8'h08); press(8'h10);
    check("ovf_digits", 32'(kp.digits), 32'h1234);
    check("ovf_count", 32'(kp.digit_count), 32'h4);
    check("ovf_flag", 32'(kp.overflow), 32'h1);
    ev_pulses = 0;
    press(8'hC0);
    check("commit_pulses", 32'(ev_pulses), 32'h1);
    check("commit_value", 32'(kp.entry_value), 32'h1234);
    check("commit_digits", 32'(kp.digits), 32'h0);
    check("commit_ovf", 32'(kp.overflow), 32'h0);

    // '#' on empty buffer
    ev_pulses = 0;
    kv_pulses = 0;
    press(8'hC0);
    check("empty_hash_kv", 32'(kv_pulses), 32'h1);
    check("empty_hash_code", 32'(kp.key_code), 32'd11);
    check("empty_hash_ev", 32'(ev_pulses), 32'h0);
    check("empty_hash_value", 32'(kp.entry_value), 32'h1234);

    // 7,8 then '*'
    press(8'h40); press(8'h80); press(8'hB0);
`ifdef KEYPAD_ENTRY_BACKSPACE_EN
    check("star_digits", 32'(kp.digits), 32'h0007);
    check("star_count", 32'(kp.digit_count), 32'h1);
`else
    check("star_digits", 32'(kp.digits), 32'h0);
    check("star_count", 32'(kp.digit_count), 32'h0);
`endif

    // Reset during PRESS_WAIT of '9', code still held afterwards
    for (int i = 0; i < 5; i++) cycle(8'h90);
    cycle(8'h90, 1'b1);
    cycle(8'h90, 1'b1);
    check("rst9_digits", 32'(kp.digits), 32'h0);
    check("rst9_entry", 32'(kp.entry_value), 32'h0);
    check("rst9_kv", 32'(kp.key_valid), 32'h0);
    first = 0;
    for (int i = 1; i <= D + 4; i++) begin
      cycle(8'h90);
      if (kp.key_valid === 1'b1 && first == 0) first = i;
    end
    check("rst9_latency", 32'(first), 32'(D));
    check("rst9_code", 32'(kp.key_code), 32'h9);
    for (int i = 0; i < D + 2; i++) cycle(8'h00);

    // Randomized bouncing keys, gaps and garbage codes
    for (int s = 0; s < 300; s++) begin
      logic [7:0] c;
      int len;
      case ($urandom_range(0, 9))
        0:       c = 8'($urandom);                          // likely invalid
        1, 2:    c = 8'h00;
        default: c = code_tab[$urandom_range(0, 11)];
      endcase
      len = $urandom_range(1, 30);
      for (int i = 0; i < len; i++) cycle(c);
      if ($urandom_range(0, 2) == 0) begin
        len = $urandom_range(1, 24);
        for (int i = 0; i < len; i++) cycle(8'h00);
      end
      if ($urandom_range(0, 99) == 0) cycle(c, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/keypad_entry.md
Name: keypad_entry

Overview:
Consumes the 8-bit key code produced by the 3x4 matrix-keypad scanner and debounces it into single-cycle key events. Decodes each event to a 4-bit key value and assembles up to four decimal digits into a BCD entry buffer. '*' edits the buffer; '#' commits it. Sits directly downstream of the scanner and feeds display and control logic with clean key events and committed 4-digit numbers.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive identical clk samples required to accept a press or a release (min 2)
MAX_DIGITS, 4, entry buffer depth in BCD digits (1..4)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
data_in  input  8  scanner key code; 0 = no key
key_valid  output  1  one-cycle pulse per accepted key press
key_code  output  4  decoded key: 0-9 digits, 10 = '*', 11 = '#'; held until the next event
digits  output  16  BCD buffer; newest digit in [3:0]
digit_count  output  3  number of valid digits in buffer (0..MAX_DIGITS)
overflow  output  1  sticky; a digit arrived while the buffer was full
entry_valid  output  1  one-cycle pulse on commit
entry_value  output  16  BCD value committed by the last '#'; held

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous and active-high. All outputs are registered.
- Reset: all outputs are 0; FSM = IDLE; debounce counter = 0.
- Code table (data_in -> key_code): 01->1, 02->2, 04->3, 08->4, 10->5, 20->6, 40->7, 80->8, 90->9, A0->0, B0->10 ('*'), C0->11 ('#'). Any other nonzero value is invalid and is treated as 0.
- FSM states:
  - IDLE: wait for a valid code. On a valid code, latch the candidate, set cnt=1, go to PRESS_WAIT.
  - PRESS_WAIT: same code present -> cnt++. Code differs or becomes 0 -> return to IDLE, or restart with the new code at cnt=1.
  - Press acceptance: when cnt reaches DEBOUNCE_CYCLES, go to HELD. On that same edge, assert key_valid for one cycle, update key_code, and apply the buffer action.
  - HELD: on data_in == 0, set cnt=1 and go to RELEASE_WAIT. Other codes are ignored; there is no second event while a key is held.
  - RELEASE_WAIT: data_in == 0 -> cnt++; reaching DEBOUNCE_CYCLES -> IDLE. Any nonzero input -> back to HELD.
- Latency: key_valid rises DEBOUNCE_CYCLES edges after the first edge that samples the stable code.
- Buffer actions, applied on the key_valid edge:
  - Digit, count < MAX_DIGITS: digits <= {digits[11:0], d}; count++.
  - Digit, count == MAX_DIGITS: buffer unchanged; overflow <= 1.
  - '*': digits <= 0; count <= 0; overflow <= 0.
  - '#' with count > 0: entry_value <= digits; entry_valid pulse; digits, count and overflow cleared.
  - '#' with count == 0: no entry_valid pulse; state unchanged.
- Digit bits above MAX_DIGITS*4 are always 0.
- Reset while in any state has priority and returns everything to reset values on that edge.

Optional Feature:
KEYPAD_ENTRY_BACKSPACE_EN
- Defined: '*' acts as backspace. digits <= {4'h0, digits[15:4]}; count decrements (saturates at 0); overflow is cleared.
- Undefined: '*' clears the whole buffer as specified above.

Decomposition:
- Package keypad_pkg holds:
  - the 12 scanner code constants
  - KEY_STAR=10 and KEY_HASH=11
  - the FSM state typedef (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT)
  - a code-to-key decode function returning {valid, key[3:0]}
- Sub-module keypad_debounce holds the FSM and counter and outputs key_valid and key_code. keypad_entry adds the buffer, overflow and commit logic on top.

Test Plan:
- Hold data_in=0x10 for 16 cycles -> exactly one key_valid, key_code=5, digits=0x0005, count=1. Hold a further 100 cycles -> no further pulse.
- data_in=0x10 for 10 cycles, 0 for 3 cycles, 0x10 again (bounce) -> key_valid occurs 16 cycles after the last rise, not before.
- Keys 1,2,3,4,5 (each pressed and released) -> digits=0x1234, count=4, overflow=1. Then '#' -> entry_valid pulse, entry_value=0x1234, digits=0, overflow=0.
- '#' with an empty buffer -> key_valid with key_code=11, no entry_valid, entry_value unchanged.
- Keys 7,8 then '*' -> digits=0 (BACKSPACE_EN: 0x0007, count=1).
- Assert reset during PRESS_WAIT of 0x90, then release reset with the code still held -> all outputs 0, and key_valid (code 9) arrives 16 cycles after reset deasserts.
